fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_imem_if.sv | 12 +
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_imem_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_imem_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage with F/D pipeline register: one outstanding imem request,
// hold buffer for words that arrive during a stall, address-error bubbles.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  fetch_imem_if.master imem,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic        D_adel
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] hold_r;
  logic        pc_legal_s;
  logic        advance_s;
  logic [31:0] word_s;
  logic        adel_s;

  assign pc_legal_s = (F_PC[1:0] == 2'b00) && (F_PC >= IMEM_LO) && (F_PC <= IMEM_HI);

  // Request is gated by reset so it drops immediately and rises on release.
  assign imem.req  = reset && (state_r == S_REQ) && pc_legal_s;
  assign imem.addr = {F_PC[31:2], 2'b00};

  // Decide whether D is loaded this edge and with which word.
  always_comb begin
    advance_s = 1'b0;
    word_s    = 32'h0000_0000;
    adel_s    = 1'b0;
    case (state_r)
      S_REQ: begin
        if (!pc_legal_s && !stall) begin
          advance_s = 1'b1;
          adel_s    = 1'b1;
        end else begin
          advance_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem.rvalid && !stall) begin
          advance_s = 1'b1;
          word_s    = imem.rdata;
        end else begin
          advance_s = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          advance_s = 1'b1;
          word_s    = hold_r;
        end else begin
          advance_s = 1'b0;
        end
      end
      default: begin
        advance_s = 1'b0;
      end
    endcase
  end

  // Fetch FSM, F_PC and the D pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_REQ;
      hold_r  <= 32'h0000_0000;
      F_PC    <= RESET_PC;
      D_PC    <= 32'h0000_0000;
      D_instr <= 32'h0000_0000;
      D_valid <= 1'b0;
      D_adel  <= 1'b0;
    end else if (advance_s) begin
      D_PC    <= F_PC;
      D_instr <= word_s;
      D_valid <= 1'b1;
      D_adel  <= adel_s;
      F_PC    <= npc;
      state_r <= S_REQ;
    end else begin
      if (!stall) begin
        D_valid <= 1'b0;
        D_instr <= 32'h0000_0000;
        D_adel  <= 1'b0;
      end
      // Without an advance, rvalid in S_WAIT can only mean a stalled response.
      case (state_r)
        S_REQ: begin
          if (pc_legal_s && imem.gnt) begin
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            hold_r  <= imem.rdata;
            state_r <= S_HOLD;
          end
        end
        S_HOLD: begin
          state_r <= S_HOLD;
        end
        default: begin
          state_r <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of the
// fetch stage (outstanding request, buffered word, D register contents).
module tb_fetch_unit;
  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic [31:0] F_PC, D_PC, D_instr;
  logic        D_valid, D_adel;

  fetch_imem_if imem_bus ();

  fetch_unit dut (
    .clk     (clk),
    .reset   (reset),
    .npc     (npc),
    .stall   (stall),
    .imem    (imem_bus),
    .F_PC    (F_PC),
    .D_PC    (D_PC),
    .D_instr (D_instr),
    .D_valid (D_valid),
    .D_adel  (D_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc, m_dpc, m_dinstr, m_buf;
  logic        m_dvalid, m_dadel, m_busy, m_buf_full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6ffc);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h2400_0000;
  endfunction

  function automatic logic exp_req();
    return !m_busy && !m_buf_full && legal(m_pc);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_dpc = 32'h0; m_dinstr = 32'h0; m_buf = 32'h0;
    m_dvalid = 1'b0; m_dadel = 1'b0; m_busy = 1'b0; m_buf_full = 1'b0;
  endtask

  // Effect of one rising edge on the model, given the inputs of this cycle.
  task automatic model_edge(input logic s, input logic [31:0] n, input logic g,
                            input logic rv, input logic [31:0] rd);
    logic        have;
    logic        err;
    logic [31:0] w;
    logic        req;
    req  = exp_req();
    have = 1'b0; err = 1'b0; w = 32'h0;
    if (m_buf_full) begin
      have = 1'b1; w = m_buf;
    end else if (m_busy && rv) begin
      have = 1'b1; w = rd;
    end else if (!m_busy && !legal(m_pc)) begin
      have = 1'b1; err = 1'b1;
    end
    if (!s && have) begin
      m_dpc = m_pc; m_dinstr = w; m_dvalid = 1'b1; m_dadel = err;
      m_pc = n; m_busy = 1'b0; m_buf_full = 1'b0;
    end else begin
      if (!s) begin
        m_dvalid = 1'b0; m_dinstr = 32'h0; m_dadel = 1'b0;
      end
      if (m_busy && rv) begin
        m_buf = rd; m_buf_full = 1'b1; m_busy = 1'b0;
      end
      if (req && g) m_busy = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("F_PC", F_PC, m_pc);
    check("D_PC", D_PC, m_dpc);
    check("D_instr", D_instr, m_dinstr);
    check("D_valid", {31'd0, D_valid}, {31'd0, m_dvalid});
    check("D_adel", {31'd0, D_adel}, {31'd0, m_dadel});
    check("imem_req", {31'd0, imem_bus.req}, {31'd0, exp_req()});
    if (exp_req()) check("imem_addr", imem_bus.addr, {m_pc[31:2], 2'b00});
  endtask

  // One clock cycle: drive inputs, advance model, check after the edge.
  task automatic step(input logic s, input logic [31:0] n, input logic g,
                      input logic rv, input logic [31:0] rd);
    stall = s; npc = n; imem_bus.gnt = g; imem_bus.rvalid = rv; imem_bus.rdata = rd;
    model_edge(s, n, g, rv, rd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_F_PC", F_PC, 32'h0000_3000);
    check("rst_D_valid", {31'd0, D_valid}, 32'd0);
    check("rst_D_instr", D_instr, 32'h0);
    check("rst_req", {31'd0, imem_bus.req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    compare_all();
  endtask

  logic [31:0] n_s;
  logic        s_s, g_s, rv_s;
  logic [31:0] rd_s;

  initial begin
    reset = 1'b0; stall = 1'b0; npc = 32'h0;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    compare_all();

    // First fetch after reset
    step(1'b0, 32'h3004, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h3004, 1'b0, 1'b1, 32'h2408_0001);
    check("first_D_PC", D_PC, 32'h3000);
    check("first_D_instr", D_instr, 32'h2408_0001);
    check("first_F_PC", F_PC, 32'h3004);

    // Response during a 3-cycle stall goes to the hold buffer
    step(1'b0, 32'h3008, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h3008, 1'b0, 1'b1, 32'hAAAA_0000);
    step(1'b1, 32'h3008, 1'b0, 1'b1, 32'h5555_5555);
    step(1'b1, 32'h3008, 1'b0, 1'b0, 32'h0);
    check("hold_D_PC", D_PC, 32'h3000);
    step(1'b0, 32'h3008, 1'b0, 1'b0, 32'h0);
    check("hold_D_instr", D_instr, 32'hAAAA_0000);

    // Grant withheld for 4 cycles
    for (int i = 0; i < 4; i++) step(1'b0, 32'h300c, 1'b0, 1'b0, 32'h0);
    check("nogt_addr", imem_bus.addr, 32'h3008);

    // Delay slot at 3008 advances with npc=3100
    step(1'b0, 32'h3100, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h3100, 1'b0, 1'b1, mem_word(32'h3008));
    check("br_D_PC", D_PC, 32'h3008);
    check("br_F_PC", F_PC, 32'h3100);
    check("br_addr", imem_bus.addr, 32'h3100);

    // Misaligned and out-of-range fetch addresses
    step(1'b0, 32'h3002, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h3002, 1'b0, 1'b1, mem_word(32'h3100));
    step(1'b0, 32'h7000, 1'b1, 1'b0, 32'h0);
    check("mis_D_adel", {31'd0, D_adel}, 32'd1);
    check("mis_D_PC", D_PC, 32'h3002);
    step(1'b1, 32'h3000, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h3000, 1'b1, 1'b0, 32'h0);
    check("oor_D_adel", {31'd0, D_adel}, 32'd1);
    check("oor_D_PC", D_PC, 32'h7000);
    check("oor_D_instr", D_instr, 32'h0);

    // Reset mid-transaction, then a late response is discarded
    step(1'b0, 32'h3004, 1'b1, 1'b0, 32'h0);
    pulse_reset();
    step(1'b0, 32'h3004, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("late_D_valid", {31'd0, D_valid}, 32'd0);
    check("late_addr", imem_bus.addr, 32'h3000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) pulse_reset();
      s_s = ($urandom_range(0, 3) == 0);
      g_s = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 19))
        0:       n_s = m_pc + 32'd2;
        1:       n_s = 32'h0000_7000;
        2:       n_s = 32'h0000_2ffc;
        3:       n_s = 32'h0000_6ffc;
        4:       n_s = 32'h0000_3000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
        5:       n_s = 32'hffff_fffc;
        default: n_s = legal(m_pc) ? m_pc + 32'd4 : 32'h0000_3000;
      endcase
      if (m_busy) begin
        rv_s = ($urandom_range(0, 9) < 6);
        rd_s = mem_word(m_pc);
      end else begin
        rv_s = !(exp_req() && g_s) && ($urandom_range(0, 6) == 0);
        rd_s = $urandom;
      end
      step(s_s, n_s, g_s, rv_s, rd_s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
